pcihellocore_led_sequencer: RTL and testbench
=============================================

PCIHELLOCORE_LED_SEQUENCER -- requirements
Module: pcihellocore_led_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, LED/pattern width in bits; legal range 2..32.
REQ-002 Parameter: PERIOD_RST, 32'd50000000, PERIOD register reset value in clk cycles.
REQ-003 Port: clk  in  1  single clock; all logic on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: address  in  2  Avalon-MM slave register select.
REQ-006 Port: chipselect  in  1  Avalon-MM slave select.
REQ-007 Port: write_n  in  1  Avalon-MM write strobe, active-low.
REQ-008 Port: writedata  in  32  Avalon-MM write data.
REQ-009 Port: readdata  out  32  Avalon-MM read data, combinational from address, zero wait states.
REQ-010 Port: out_port  out  WIDTH  registered LED drive.
REQ-011 Port (only with LED_SEQ_IRQ_EN): irq  out  1  level interrupt, active-high.

Function
REQ-012 Register map SHALL be: 0 CTRL (bit0 EN, bits2:1 MODE), 1 PATTERN (bits WIDTH-1:0), 2 PERIOD (bits 31:0), 3 STATUS (read: bit0 RUN, bit1 DIR, bit2 WRAP, bits 12:8 STEP; write: clears WRAP).
REQ-013 Write occurs when chipselect=1 and write_n=0; unused register bits SHALL read 0.
REQ-014 State machine SHALL have two states: IDLE (EN=0) and RUN (EN=1); transition occurs on the clock edge that writes EN.
REQ-015 In IDLE, out_port SHALL equal PATTERN, one cycle after any PATTERN write; prescaler, STEP, and DIR held at 0.
REQ-016 On IDLE->RUN, working register SHALL load PATTERN; prescaler, STEP, and DIR (0 = left) SHALL clear.
REQ-017 In RUN, prescaler SHALL increment each cycle; when it equals max(PERIOD,1)-1 it SHALL clear and a step SHALL occur; PERIOD=0 behaves as PERIOD=1 (step every cycle).
REQ-018 MODE 0 (static): step leaves out_port unchanged.
REQ-019 MODE 1 (blink): step toggles out_port between PATTERN and 0, starting with PATTERN.
REQ-020 MODE 2 (rotate): step rotates out_port left by 1; MSB wraps into LSB.
REQ-021 MODE 3 (bounce): step does a logical shift in direction DIR; if the bit about to leave (MSB for left, LSB for right) is 1, DIR SHALL flip instead of shifting; all-zero pattern stays zero, DIR constant.
REQ-022 STEP SHALL count steps modulo WIDTH; on wrap from WIDTH-1 to 0, WRAP SHALL set and stay set until a STATUS write.
REQ-023 Simultaneous wrap and STATUS write SHALL leave WRAP set (set wins).
REQ-024 PATTERN or PERIOD write in RUN SHALL reload working register from new PATTERN, clear prescaler, STEP, and DIR; WRAP unaffected.
REQ-025 MODE change in RUN SHALL take effect at the next step with no reload.
REQ-026 RUN->IDLE SHALL return out_port to PATTERN on the next cycle.

Reset
REQ-027 Reset SHALL set CTRL=0, PATTERN=0, PERIOD=PERIOD_RST, prescaler=0, STEP=0, DIR=0, WRAP=0, out_port=0, state=IDLE.
REQ-028 Reset SHALL override any concurrent write; asserting reset mid-RUN SHALL abort the sequence within one cycle.

Configuration
REQ-029 With macro PCIHELLOCORE_LED_SEQ_IRQ_EN defined, port irq SHALL exist and equal WRAP AND CTRL bit3 (IE), IE readable/writable.
REQ-030 Without PCIHELLOCORE_LED_SEQ_IRQ_EN, irq port and IE bit SHALL be absent; CTRL bit3 SHALL read 0; WRAP still functional via STATUS.

Verification
REQ-031 Reset, then read all 4 addresses -> CTRL=0, PATTERN=0, PERIOD=50000000, STATUS=0; out_port=0.
REQ-032 PATTERN=0x1, PERIOD=4, CTRL=0x5 (EN, rotate) -> out_port 0x1, 0x2, 0x4 at 4-cycle spacing; after 32 steps out_port=0x1, STATUS WRAP=1.
REQ-033 PATTERN=0xC0000000, PERIOD=0, CTRL=0x7 (bounce) -> first step DIR flips with out_port unchanged, then 0x60000000, 0x30000000 on successive cycles.
REQ-034 PATTERN=0xAA, PERIOD=2, CTRL=0x3 (blink) -> out_port 0xAA, 0x00, 0xAA toggling every 2 cycles; CTRL=0 -> out_port=0xAA next cycle.
REQ-035 Running rotate, write PATTERN=0x8 mid-period -> out_port=0x8 next cycle, STEP=0, next step exactly PERIOD cycles later; assert reset same cycle as a write -> all registers at reset values.
REQ-036 With PCIHELLOCORE_LED_SEQ_IRQ_EN, CTRL=0xD, PERIOD=1, PATTERN=0x1 -> irq=1 after 32 cycles; STATUS write -> irq=0 next cycle unless a wrap coincides.

Source files
------------

// File: rtl/pcihellocore_led_sequencer.sv
// Avalon-MM LED sequencer: static, blink, rotate and bounce patterns stepped by a prescaler.
// Define PCIHELLOCORE_LED_SEQ_IRQ_EN to add the CTRL.IE bit and the irq output (WRAP & IE).
module pcihellocore_led_sequencer #(
    parameter int          WIDTH      = 32,
    parameter logic [31:0] PERIOD_RST = 32'd50000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
`ifdef PCIHELLOCORE_LED_SEQ_IRQ_EN
    ,
    output logic             irq
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [4:0] STEP_LAST = 5'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic [31:0]      period_q, period_d;
    logic [31:0]      presc_q, presc_d;
    logic [31:0]      presc_last;
    logic [4:0]       step_q, step_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic             wrap_set;
    logic [WIDTH-1:0] work_q, work_d;
    logic             wr, wr_ctrl, wr_pat, wr_per, wr_stat;

    assign wr      = chipselect & ~write_n;
    assign wr_ctrl = wr && (address == 2'd0);
    assign wr_pat  = wr && (address == 2'd1);
    assign wr_per  = wr && (address == 2'd2);
    assign wr_stat = wr && (address == 2'd3);

    // PERIOD=0 is treated like PERIOD=1: the prescaler terminal count is 0.
    assign presc_last = (period_q == 32'd0) ? 32'd0 : period_q - 32'd1;

`ifdef PCIHELLOCORE_LED_SEQ_IRQ_EN
    logic ie_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ie_q <= 1'b0;
        end else if (wr_ctrl) begin
            ie_q <= writedata[3];
        end
    end

    assign irq = wrap_q & ie_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mode_q    <= 2'd0;
            pattern_q <= '0;
            period_q  <= PERIOD_RST;
            presc_q   <= 32'd0;
            step_q    <= 5'd0;
            dir_q     <= 1'b0;
            wrap_q    <= 1'b0;
            work_q    <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            pattern_q <= pattern_d;
            period_q  <= period_d;
            presc_q   <= presc_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            wrap_q    <= wrap_d;
            work_q    <= work_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        pattern_d = pattern_q;
        period_d  = period_q;
        presc_d   = presc_q;
        step_d    = step_q;
        dir_d     = dir_q;
        work_d    = work_q;
        wrap_set  = 1'b0;

        if (wr_ctrl) begin
            state_d = writedata[0] ? RUN : IDLE;
            mode_d  = writedata[2:1];
        end
        if (wr_pat) pattern_d = writedata[WIDTH-1:0];
        if (wr_per) period_d  = writedata;

        if (state_d == IDLE) begin
            presc_d = 32'd0;
            step_d  = 5'd0;
            dir_d   = 1'b0;
            work_d  = pattern_d;
        end else if (state_q == IDLE || wr_pat || wr_per) begin
            // Start or restart the sequence from the (possibly new) pattern.
            presc_d = 32'd0;
            step_d  = 5'd0;
            dir_d   = 1'b0;
            work_d  = pattern_d;
        end else if (presc_q == presc_last) begin
            presc_d  = 32'd0;
            wrap_set = (step_q == STEP_LAST);
            step_d   = (step_q == STEP_LAST) ? 5'd0 : step_q + 5'd1;
            case (mode_q)
                2'd0: work_d = work_q;
                2'd1: work_d = (work_q != '0) ? '0 : pattern_q;
                2'd2: work_d = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
                default: begin
                    // Bounce: reverse instead of shifting a set bit off the edge.
                    if (!dir_q) begin
                        if (work_q[WIDTH-1]) dir_d = 1'b1;
                        else                 work_d = {work_q[WIDTH-2:0], 1'b0};
                    end else begin
                        if (work_q[0]) dir_d = 1'b0;
                        else           work_d = {1'b0, work_q[WIDTH-1:1]};
                    end
                end
            endcase
        end else begin
            presc_d = presc_q + 32'd1;
        end

        // A wrap on the same edge as a STATUS write keeps WRAP set.
        wrap_d = wrap_set | (wrap_q & ~wr_stat);
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0: begin
                readdata[0]   = (state_q == RUN);
                readdata[2:1] = mode_q;
`ifdef PCIHELLOCORE_LED_SEQ_IRQ_EN
                readdata[3]   = ie_q;
`endif
            end
            2'd1: readdata[WIDTH-1:0] = pattern_q;
            2'd2: readdata = period_q;
            default: begin
                readdata[0]    = (state_q == RUN);
                readdata[1]    = dir_q;
                readdata[2]    = wrap_q;
                readdata[12:8] = step_q;
            end
        endcase
    end

    assign out_port = work_q;

endmodule

// File: tb/tb_pcihellocore_led_sequencer.sv
// Directed testbench for pcihellocore_led_sequencer (WIDTH=32); checks use immediate assertions.
// Define PCIHELLOCORE_LED_SEQ_IRQ_EN to also exercise the irq output.
module tb_pcihellocore_led_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] out_port;
`ifdef PCIHELLOCORE_LED_SEQ_IRQ_EN
    logic        irq;
`endif

    int n_vec = 0;
    int n_err = 0;

    pcihellocore_led_sequencer #(
        .WIDTH      (32),
        .PERIOD_RST (32'd50000000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
`ifdef PCIHELLOCORE_LED_SEQ_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(tag, readdata, exp);
    endtask

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        tick(2);
        reset = 1'b0;

        // Reset values
        read_check("rst_ctrl", 2'd0, 32'h0);
        read_check("rst_pattern", 2'd1, 32'h0);
        read_check("rst_period", 2'd2, 32'd50000000);
        read_check("rst_status", 2'd3, 32'h0);
        check("rst_out", out_port, 32'h0);

        // Rotate, PERIOD=4
        bus_write(2'd1, 32'h1);
        check("idle_pat_out", out_port, 32'h1);
        bus_write(2'd2, 32'd4);
        bus_write(2'd0, 32'h5);
        check("rot_start", out_port, 32'h1);
        tick(3);
        check("rot_hold", out_port, 32'h1);
        tick(1);
        check("rot_step1", out_port, 32'h2);
        tick(4);
        check("rot_step2", out_port, 32'h4);
        read_check("rot_status2", 2'd3, 32'h201);
        tick(120);
        check("rot_step32", out_port, 32'h1);
        read_check("rot_wrap", 2'd3, 32'h5);
        bus_write(2'd3, 32'h0);
        read_check("wrap_clear", 2'd3, 32'h1);

        // Mid-period PATTERN write reloads and restarts the prescaler
        bus_write(2'd1, 32'h8);
        check("reload_out", out_port, 32'h8);
        read_check("reload_status", 2'd3, 32'h1);
        tick(3);
        check("reload_hold", out_port, 32'h8);
        tick(1);
        check("reload_step", out_port, 32'h10);

        bus_write(2'd0, 32'h0);
        check("stop_out", out_port, 32'h8);
        read_check("stop_status", 2'd3, 32'h0);

        // Bounce, PERIOD=0
        bus_write(2'd1, 32'hC000_0000);
        bus_write(2'd2, 32'd0);
        bus_write(2'd0, 32'h7);
        check("bnc_start", out_port, 32'hC000_0000);
        tick(1);
        check("bnc_flip", out_port, 32'hC000_0000);
        read_check("bnc_status", 2'd3, 32'h103);
        tick(1);
        check("bnc_sh1", out_port, 32'h6000_0000);
        tick(1);
        check("bnc_sh2", out_port, 32'h3000_0000);
        bus_write(2'd0, 32'h0);

        // Blink, PERIOD=2
        bus_write(2'd1, 32'hAA);
        bus_write(2'd2, 32'd2);
        bus_write(2'd0, 32'h3);
        tick(1);
        check("blk_on", out_port, 32'hAA);
        tick(1);
        check("blk_off", out_port, 32'h0);
        tick(1);
        check("blk_off_hold", out_port, 32'h0);
        tick(1);
        check("blk_on2", out_port, 32'hAA);
        bus_write(2'd0, 32'h0);
        check("blk_stop", out_port, 32'hAA);

        // Bounce of an all-zero pattern
        bus_write(2'd1, 32'h0);
        bus_write(2'd2, 32'd0);
        bus_write(2'd0, 32'h7);
        tick(3);
        check("bnc_zero_out", out_port, 32'h0);
        read_check("bnc_zero_status", 2'd3, 32'h301);
        bus_write(2'd0, 32'h0);

        // Mode change in RUN takes effect at the next step, no reload
        bus_write(2'd1, 32'h1);
        bus_write(2'd0, 32'h5);
        tick(1);
        check("mc_rot", out_port, 32'h2);
        bus_write(2'd0, 32'h3);
        check("mc_old_mode", out_port, 32'h4);
        tick(1);
        check("mc_blink_off", out_port, 32'h0);
        tick(1);
        check("mc_blink_on", out_port, 32'h1);
        bus_write(2'd0, 32'h0);

        // Unused CTRL bits read 0
        bus_write(2'd0, 32'hFFFF_FFFF);
`ifdef PCIHELLOCORE_LED_SEQ_IRQ_EN
        read_check("ctrl_unused", 2'd0, 32'hF);
`else
        read_check("ctrl_unused", 2'd0, 32'h7);
`endif
        bus_write(2'd0, 32'h0);

        // Wrap coinciding with a STATUS write keeps WRAP set
        bus_write(2'd3, 32'h0);
        bus_write(2'd0, 32'h5);
        tick(31);
        bus_write(2'd3, 32'h0);
        read_check("wrap_set_wins", 2'd3, 32'h5);
        bus_write(2'd3, 32'h0);
        read_check("wrap_then_clear", 2'd3, 32'h101);

`ifdef PCIHELLOCORE_LED_SEQ_IRQ_EN
        bus_write(2'd0, 32'h0);
        bus_write(2'd3, 32'h0);
        bus_write(2'd2, 32'd1);
        bus_write(2'd1, 32'h1);
        bus_write(2'd0, 32'hD);
        tick(31);
        check("irq_low", {31'd0, irq}, 32'h0);
        tick(1);
        check("irq_high", {31'd0, irq}, 32'h1);
        bus_write(2'd3, 32'h0);
        check("irq_clear", {31'd0, irq}, 32'h0);
        bus_write(2'd0, 32'h5);
`endif

        // Reset asserted mid-RUN together with a write
        address    = 2'd1;
        writedata  = 32'h55;
        chipselect = 1'b1;
        write_n    = 1'b0;
        reset      = 1'b1;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        reset      = 1'b0;
        check("rst2_out", out_port, 32'h0);
        read_check("rst2_ctrl", 2'd0, 32'h0);
        read_check("rst2_pattern", 2'd1, 32'h0);
        read_check("rst2_period", 2'd2, 32'd50000000);
        read_check("rst2_status", 2'd3, 32'h0);
        tick(2);
        check("rst2_out_hold", out_port, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
